// File: rtl/wb_la_master.sv
// wb_la_master: Wishbone classic single-transfer initiator.
//
// Issues one read or write at a time towards the user-project Wishbone slave.
// A command handshake (cmd_valid_i/cmd_ready_o) starts a bus cycle. The cycle
// ends on the slave's ACK, or it is aborted after TIMEOUT clocks. Either way
// the result comes back as a one-cycle rsp_valid_o pulse. Saturating counters
// keep track of acked and timed-out transfers.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   cmd_*                    command: valid/ready, we, adr, dat, sel
//   rsp_valid_o/err_o/dat_o  completion pulse, timeout flag, read data
//   wbm_*                    Wishbone master signals towards the slave
//   busy_o                   bus cycle in progress
//   ok_cnt_o, err_cnt_o      acked / timed-out transfer counts (saturating)
module wb_la_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic [31:0]      rsp_dat_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] ok_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Timeout counter wide enough to hold TIMEOUT; one bit when disabled.
    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     tcnt_q;
    logic              cyc_q;
    logic              we_q;
    logic [31:0]       adr_q;
    logic [31:0]       dat_q;
    logic [3:0]        sel_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_dat_q;
    logic [CNT_W-1:0]  ok_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A stray ACK here is ignored on purpose.
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        adr_q   <= cmd_adr_i;
                        dat_q   <= cmd_dat_i;
                        sel_q   <= cmd_sel_i;
                        cyc_q   <= 1'b1;
                        tcnt_q  <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout on the same edge.
                    if (wbm_ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        if (!we_q)
                            rsp_dat_q <= wbm_dat_i;
                        if (ok_cnt_q != '1)
                            ok_cnt_q <= ok_cnt_q + 1'b1;
                        state_q <= IDLE;
                    end else if ((TIMEOUT != 0) && (tcnt_q == T_LAST)) begin
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= '0;
                        if (err_cnt_q != '1)
                            err_cnt_q <= err_cnt_q + 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // In IDLE the master is always ready to take a command.
    assign cmd_ready_o = (state_q == IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign busy_o      = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign ok_cnt_o    = ok_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
